// File: rtl/sort_seq_pkg.sv
// Shared types and widths for the sequential sort controller.
package sort_seq_pkg;

  localparam int DATA_W     = 4;
  localparam int SWAP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

endpackage

// File: rtl/comparator4bit.sv
// 4-bit unsigned magnitude comparator.
module comparator4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       aeb,
  output logic       agb,
  output logic       alb
);

  assign aeb = (a == b);
  assign agb = (a > b);
  assign alb = (a < b);

endmodule

// File: rtl/sort_seq_ctrl.sv
// Bubble-sort controller over a small register array, one compare per clock
// through a single shared comparator, with early exit on a swap-free pass.
module sort_seq_ctrl
  import sort_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]         r_idx;
  logic [AW-1:0]         w_idx_next;
  logic [AW-1:0]         r_pass;
  logic [AW-1:0]         w_pass_next;
  logic                  r_pass_swapped;
  logic                  w_swapped_next;
  logic [SWAP_CNT_W-1:0] r_swap_cnt;
  logic [SWAP_CNT_W-1:0] w_cnt_next;

  logic [AW-1:0]         w_idx_b;
  logic [DATA_W-1:0]     w_a;
  logic [DATA_W-1:0]     w_b;
  logic                  w_aeb;
  logic                  w_agb;
  logic                  w_alb;
  logic [1:0]            w_unused_cmp;
  logic                  w_do_swap;
  logic                  w_last;
  logic                  w_final_pass;

  // Operand mux: adjacent pair at the current index feeds the comparator.
  assign w_idx_b = r_idx + AW'(1);
  assign w_a     = r_mem[r_idx];
  assign w_b     = r_mem[w_idx_b];

  comparator4bit u_cmp (
    .a   (w_a),
    .b   (w_b),
    .aeb (w_aeb),
    .agb (w_agb),
    .alb (w_alb)
  );

  // Only agb matters; equal values are left in place so the sort is stable.
  assign w_unused_cmp = {w_aeb, w_alb};

  // Each pass shrinks by one since the largest remaining value bubbles to the end.
  assign w_last       = (int'(r_idx) == DEPTH - 2 - int'(r_pass));
  assign w_final_pass = (int'(r_pass) == DEPTH - 2);

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign swap_cnt = r_swap_cnt;

  // Combinational read port; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) rd_data = r_mem[rd_addr];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and sequencing counters.
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_pass_next    = r_pass;
    w_swapped_next = r_pass_swapped;
    w_cnt_next     = r_swap_cnt;
    w_do_swap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next   = CMP;
          w_idx_next     = '0;
          w_pass_next    = '0;
          w_swapped_next = 1'b0;
          w_cnt_next     = '0;
        end
      end
      CMP: begin
        w_do_swap = w_agb;
        if (w_agb) begin
          w_cnt_next     = r_swap_cnt + SWAP_CNT_W'(1);
          w_swapped_next = 1'b1;
        end
        if (!w_last) begin
          w_idx_next = r_idx + AW'(1);
        end else if (!(r_pass_swapped || w_agb) || w_final_pass) begin
          w_state_next = DONE;
        end else begin
          w_pass_next    = r_pass + AW'(1);
          w_idx_next     = '0;
          w_swapped_next = 1'b0;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Sequencing counters and swap count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx          <= '0;
      r_pass         <= '0;
      r_pass_swapped <= 1'b0;
      r_swap_cnt     <= '0;
    end else begin
      r_idx          <= w_idx_next;
      r_pass         <= w_pass_next;
      r_pass_swapped <= w_swapped_next;
      r_swap_cnt     <= w_cnt_next;
    end
  end

  // Array storage: host writes only while idle, swaps only during compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == IDLE) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) r_mem[wr_addr] <= wr_data;
    end else if (w_do_swap) begin
      r_mem[r_idx]   <= w_b;
      r_mem[w_idx_b] <= w_a;
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl (DEPTH=4).
module tb_sort_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       start;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       busy;
  logic       done;
  logic [7:0] swap_cnt;

  int checks   = 0;
  int failures = 0;

  sort_seq_ctrl #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic write(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load(input int d0, input int d1, input int d2, input int d3);
    write(2'd0, 4'(d0));
    write(2'd1, 4'(d1));
    write(2'd2, 4'(d2));
    write(2'd3, 4'(d3));
  endtask

  task automatic chk_mem(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_arr[4];
    exp_arr = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), int'(rd_data), exp_arr[i]);
    end
  endtask

  // Starts a sort and watches a fixed window; cycle c of the window is E0+c.
  task automatic run_sort(input int inj_cyc, input bit wr_also, input logic [1:0] wa,
                          input logic [3:0] wd, output int done_cyc,
                          output int busy_cnt, output int pulses);
    start = 1'b1;
    if (wr_also) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    done_cyc = -1; busy_cnt = 0; pulses = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == inj_cyc) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd5; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  initial begin
    int dc, bc, pc;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_swap", int'(swap_cnt), 0);
    chk_mem("rst", 0, 0, 0, 0);
    @(posedge clk); #1;

    // Already sorted: one pass, no swaps.
    load(1, 2, 3, 4);
    run_sort(0, 1'b0, 2'd0, 4'd0, dc, bc, pc);
    chk("sorted_done_cyc", dc, 4);
    chk("sorted_busy_cnt", bc, 4);
    chk("sorted_pulses", pc, 1);
    chk("sorted_swap", int'(swap_cnt), 0);
    chk_mem("sorted", 1, 2, 3, 4);

    // Reverse: worst case.
    load(15, 9, 4, 0);
    run_sort(0, 1'b0, 2'd0, 4'd0, dc, bc, pc);
    chk("rev_done_cyc", dc, 7);
    chk("rev_busy_cnt", bc, 7);
    chk("rev_pulses", pc, 1);
    chk("rev_swap", int'(swap_cnt), 6);
    chk_mem("rev", 0, 4, 9, 15);

    // Duplicates: final length-1 pass still runs.
    load(7, 3, 7, 3);
    run_sort(0, 1'b0, 2'd0, 4'd0, dc, bc, pc);
    chk("dup_done_cyc", dc, 7);
    chk("dup_swap", int'(swap_cnt), 3);
    chk_mem("dup", 3, 3, 7, 7);

    // Write and start while busy are ignored.
    load(15, 9, 4, 0);
    run_sort(2, 1'b0, 2'd0, 4'd0, dc, bc, pc);
    chk("busy_done_cyc", dc, 7);
    chk("busy_pulses", pc, 1);
    chk("busy_swap", int'(swap_cnt), 6);
    chk_mem("busy", 0, 4, 9, 15);

    // Reset during the sort clears everything immediately.
    load(15, 9, 4, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_swap", int'(swap_cnt), 0);
    chk_mem("mid", 0, 0, 0, 0);
    rst = 1'b0;
    pc = 0; bc = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) pc++;
      if (busy) bc++;
    end
    chk("mid_no_done", pc, 0);
    chk("mid_no_busy", bc, 0);

    // Write and start in the same idle cycle.
    load(1, 2, 3, 4);
    run_sort(0, 1'b1, 2'd3, 4'd0, dc, bc, pc);
    chk("same_done_cyc", dc, 7);
    chk("same_swap", int'(swap_cnt), 3);
    chk_mem("same", 0, 1, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
